// File: rtl/serial_cmp_pkg.sv
// Shared constants for the serial comparator encoder: symbol codes and FSM states.
// Optional feature macro: SERIAL_CMP_GAP_EN (adds the one-cycle GAP state).
package serial_cmp_pkg;

  localparam int unsigned SYM_W = 2;
  localparam int unsigned ST_W  = 2;

  // Symbol codes carried on {y,z}
  localparam logic [SYM_W-1:0] SYM_IDLE = 2'b00;
  localparam logic [SYM_W-1:0] SYM_EQ   = 2'b01;
  localparam logic [SYM_W-1:0] SYM_AGT  = 2'b10;
  localparam logic [SYM_W-1:0] SYM_BGT  = 2'b11;

  // FSM state encoding; GAP exists only when the gap feature is built in
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
`ifdef SERIAL_CMP_GAP_EN
    ST_GAP  = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_e;

  // Bit-index counter width; a 1-bit word still needs a 1-bit counter
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_cmp_encoder_if.sv
// Request/symbol bundle between a word source, the encoder and the downstream comparator.
interface serial_cmp_encoder_if #(
  parameter int unsigned N = 3
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sym_ready;
  logic         y;
  logic         z;
  logic         sym_valid;
  logic         busy;
  logic         done;
  logic [1:0]   result;

  // Requester side: drives words and downstream ready, observes symbols/status
  modport master (
    output start, a, b, sym_ready,
    input  y, z, sym_valid, busy, done, result
  );

  // Encoder side
  modport slave (
    input  start, a, b, sym_ready,
    output y, z, sym_valid, busy, done, result
  );

endinterface

// File: rtl/serial_cmp_encoder_classify.sv
// Combinational per-bit classifier: maps one bit of A and B to a comparison symbol.
module cmp_bit_classify
  import serial_cmp_pkg::*;
(
  input  logic             a_bit,
  input  logic             b_bit,
  output logic [SYM_W-1:0] sym_c
);

  // Equal bits give EQ; otherwise the word holding the 1 is greater
  always_comb begin
    sym_c = SYM_EQ;
    if (a_bit && !b_bit) begin
      sym_c = SYM_AGT;
    end else if (!a_bit && b_bit) begin
      sym_c = SYM_BGT;
    end
  end

endmodule

// File: rtl/serial_cmp_encoder.sv
// Serialises two N-bit words MSB first as {y,z} comparison symbols, stopping at the
// first differing bit. Build option SERIAL_CMP_GAP_EN inserts one idle cycle after
// every EQ symbol that is not the last bit.
module serial_cmp_encoder
  import serial_cmp_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_cmp_encoder_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(N);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [SYM_W-1:0]   result_q, result_d;
  logic               y_q, y_d;
  logic               z_q, z_d;
  logic               sym_valid_q, sym_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cls_a;
  logic               cls_b;
  logic [SYM_W-1:0]   cls_sym;
  logic [IDX_W-1:0]   idx_dec;
  logic               xfer;

  // Single classifier, fed with whichever bit the next SEND cycle will present
  cmp_bit_classify u_classify (
    .a_bit (cls_a),
    .b_bit (cls_b),
    .sym_c (cls_sym)
  );

  assign idx_dec = index_q - IDX_W'(1);
  assign xfer    = sym_valid_q && bus.sym_ready;

  // Next-state, counter, capture and next-output computation
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cls_a    = a_q[index_q];
    cls_b    = b_q[index_q];

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          index_d  = IDX_W'(N - 1);
          result_d = SYM_IDLE;
          state_d  = ST_SEND;
          cls_a    = bus.a[N-1];
          cls_b    = bus.b[N-1];
        end
      end

      ST_SEND: begin
        if (xfer) begin
          if ({y_q, z_q} != SYM_EQ) begin
            result_d = {y_q, z_q};
            state_d  = ST_DONE;
          end else if (index_q == '0) begin
            result_d = SYM_EQ;
            state_d  = ST_DONE;
          end else begin
            index_d = idx_dec;
            cls_a   = a_q[idx_dec];
            cls_b   = b_q[idx_dec];
`ifdef SERIAL_CMP_GAP_EN
            state_d = ST_GAP;
`endif
          end
        end
      end

`ifdef SERIAL_CMP_GAP_EN
      ST_GAP: begin
        state_d = ST_SEND;
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sym_valid_d = (state_d == ST_SEND);
    {y_d, z_d}  = (state_d == ST_SEND) ? cls_sym : SYM_IDLE;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      index_q     <= IDX_W'(N - 1);
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= SYM_IDLE;
      y_q         <= 1'b0;
      z_q         <= 1'b0;
      sym_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      y_q         <= y_d;
      z_q         <= z_d;
      sym_valid_q <= sym_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.z         = z_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_serial_cmp_encoder.sv
// Directed bench for serial_cmp_encoder (N=3). Inputs change and outputs are
// sampled on the falling clock edge. Status vector = {sym_valid,y,z,busy,done}.
module tb_serial_cmp_encoder;
  import serial_cmp_pkg::*;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_cmp_encoder_if #(.N(N)) bus ();

  serial_cmp_encoder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [4:0] status();
    return {bus.sym_valid, bus.y, bus.z, bus.busy, bus.done};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sym_ready = 1'b0;
    #12;
    checks++;
    if (status() !== 5'b0_00_0_0) begin
      errors++; $display("FAIL reset_status: got %b want 00000", status());
    end
    checks++;
    if (bus.result !== 2'b00) begin
      errors++; $display("FAIL reset_result: got %b want 00", bus.result);
    end
  endtask

  // a=011 b=001: EQ then AGT; start issued on the edge right after reset release
  task automatic test_eq_agt();
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1; bus.a = 3'b011; bus.b = 3'b001; bus.sym_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (status() !== 5'b1_01_1_0) begin
      errors++; $display("FAIL eq_agt_sym0: got %b want 10110", status());
    end
`ifdef SERIAL_CMP_GAP_EN
    @(negedge clk);
    checks++;
    if (status() !== 5'b0_00_1_0) begin
      errors++; $display("FAIL eq_agt_gap: got %b want 00010", status());
    end
`endif
    @(negedge clk);
    checks++;
    if (status() !== 5'b1_10_1_0) begin
      errors++; $display("FAIL eq_agt_sym1: got %b want 11010", status());
    end
    @(negedge clk);
    checks++;
    if (status() !== 5'b0_00_1_1) begin
      errors++; $display("FAIL eq_agt_done: got %b want 00011", status());
    end
    checks++;
    if (bus.result !== SYM_AGT) begin
      errors++; $display("FAIL eq_agt_result: got %b want 10", bus.result);
    end
    @(negedge clk);
    checks++;
    if (status() !== 5'b0_00_0_0) begin
      errors++; $display("FAIL eq_agt_idle: got %b want 00000", status());
    end
    checks++;
    if (bus.result !== SYM_AGT) begin
      errors++; $display("FAIL eq_agt_result_hold: got %b want 10", bus.result);
    end
  endtask

  // a=b=101: three EQ symbols, one done, busy for 4 cycles (6 with gaps)
  task automatic test_all_eq();
    int busy_cyc = 0;
    int eq_syms  = 0;
    int dones    = 0;
`ifdef SERIAL_CMP_GAP_EN
    int busy_exp = 6;
`else
    int busy_exp = 4;
`endif
    @(negedge clk);
    bus.start = 1'b1; bus.a = 3'b101; bus.b = 3'b101; bus.sym_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_cyc++;
      if (bus.sym_valid && {bus.y, bus.z} == SYM_EQ) eq_syms++;
      if (bus.done) dones++;
    end
    checks++;
    if (busy_cyc !== busy_exp) begin
      errors++; $display("FAIL all_eq_busy_cycles: got %0d want %0d", busy_cyc, busy_exp);
    end
    checks++;
    if (eq_syms !== 3) begin
      errors++; $display("FAIL all_eq_symbols: got %0d want 3", eq_syms);
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL all_eq_done_pulses: got %0d want 1", dones);
    end
    checks++;
    if (bus.result !== SYM_EQ) begin
      errors++; $display("FAIL all_eq_result: got %b want 01", bus.result);
    end
  endtask

  // a=001 b=100: BGT held stable while sym_ready is low, transfers once it rises
  task automatic test_hold();
    @(negedge clk);
    bus.start = 1'b1; bus.a = 3'b001; bus.b = 3'b100; bus.sym_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (status() !== 5'b1_11_1_0) begin
        errors++; $display("FAIL hold_sym%0d: got %b want 11110", k, status());
      end
    end
    bus.sym_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (status() !== 5'b0_00_1_1) begin
      errors++; $display("FAIL hold_done: got %b want 00011", status());
    end
    checks++;
    if (bus.result !== SYM_BGT) begin
      errors++; $display("FAIL hold_result: got %b want 11", bus.result);
    end
    @(negedge clk);
  endtask

  // Reset during the second symbol of 000/000 aborts; restart 010/000 gives AGT
  task automatic test_reset_abort();
    logic [3:0] seq;
    int         nsym;
    bit         seen_done;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 3'b000; bus.b = 3'b000; bus.sym_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sym_ready = 1'b1;
`ifdef SERIAL_CMP_GAP_EN
    @(negedge clk);
`endif
    @(negedge clk);
    checks++;
    if (status() !== 5'b1_01_1_0) begin
      errors++; $display("FAIL abort_second_sym: got %b want 10110", status());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({status(), bus.result} !== 7'b0) begin
      errors++; $display("FAIL abort_async_clear: got %b want 0000000", {status(), bus.result});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (status() !== 5'b0_00_0_0) begin
        errors++; $display("FAIL abort_idle%0d: got %b want 00000", k, status());
      end
    end
    bus.start = 1'b1; bus.a = 3'b010; bus.b = 3'b000;
    seq = '0; nsym = 0; seen_done = 1'b0;
    for (int k = 0; k < 12 && !seen_done; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.sym_valid) begin
        seq = {seq[1:0], bus.y, bus.z};
        nsym++;
      end
      if (bus.done) seen_done = 1'b1;
    end
    checks++;
    if (!seen_done) begin
      errors++; $display("FAIL restart_timeout: got no done want done within 12 cycles");
    end
    checks++;
    if (nsym !== 2 || seq !== 4'b01_10) begin
      errors++; $display("FAIL restart_symbols: got n=%0d seq=%b want n=2 seq=0110", nsym, seq);
    end
    checks++;
    if (bus.result !== SYM_AGT) begin
      errors++; $display("FAIL restart_result: got %b want 10", bus.result);
    end
    @(negedge clk);
  endtask

  // start held through a comparison with changing words: original completes,
  // new request accepted only from IDLE
  task automatic test_back_to_back();
    logic [5:0] seq;
    int         nsym;
    bit         seen_done;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 3'b101; bus.b = 3'b100; bus.sym_ready = 1'b1;
    seq = '0; nsym = 0; seen_done = 1'b0;
    for (int k = 0; k < 16 && !seen_done; k++) begin
      @(negedge clk);
      bus.a = 3'b000; bus.b = 3'b111;
      if (bus.sym_valid) begin
        seq = {seq[3:0], bus.y, bus.z};
        nsym++;
      end
      if (bus.done) seen_done = 1'b1;
    end
    checks++;
    if (!seen_done) begin
      errors++; $display("FAIL b2b_timeout: got no done want done within 16 cycles");
    end
    checks++;
    if (nsym !== 3 || seq !== 6'b01_01_10) begin
      errors++; $display("FAIL b2b_symbols: got n=%0d seq=%b want n=3 seq=010110", nsym, seq);
    end
    checks++;
    if (bus.result !== SYM_AGT) begin
      errors++; $display("FAIL b2b_result: got %b want 10", bus.result);
    end
    @(negedge clk);
    checks++;
    if (status() !== 5'b0_00_0_0) begin
      errors++; $display("FAIL b2b_idle_gap: got %b want 00000", status());
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (status() !== 5'b1_11_1_0) begin
      errors++; $display("FAIL b2b_new_sym: got %b want 11110", status());
    end
    @(negedge clk);
    checks++;
    if (status() !== 5'b0_00_1_1 || bus.result !== SYM_BGT) begin
      errors++; $display("FAIL b2b_new_done: got %b/%b want 00011/11", status(), bus.result);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_eq_agt();
    test_all_eq();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
